sample_io_buffer: RTL and testbench

Elastic sample buffer between the external sample streams and the converter core. Accepts input samples on a valid/ready stream into an input FIFO and delivers one sample to the register file per controller `new_in` request. On each `new_out` request it captures the result sample read from the register file into an output FIFO, which drains on a valid/ready stream. It absorbs the rate mismatch between external clients and the controller's S1–S8 sequence, and records underrun and overflow conditions.

---
 rtl/sample_io_buffer_if.sv | 13 +
 rtl/sample_io_buffer.sv | 93 +++++++++
 tb/tb_sample_io_buffer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_io_buffer_if.sv
// sample_io_buffer_if: input and output sample streams of sample_io_buffer.
interface sample_io_buffer_if #(parameter int DATA_W = 16);
  logic [DATA_W-1:0] s_in_data;
  logic              s_in_valid;
  logic              s_in_ready;
  logic [DATA_W-1:0] m_out_data;
  logic              m_out_valid;
  logic              m_out_ready;
  modport master(output s_in_data, s_in_valid, m_out_ready,
                 input s_in_ready, m_out_data, m_out_valid);
  modport slave(input s_in_data, s_in_valid, m_out_ready,
                output s_in_ready, m_out_data, m_out_valid);
endinterface

// File: rtl/sample_io_buffer.sv
// sample_io_buffer: elastic input/output sample FIFOs between streams and the converter core.
// Define SIO_HOLD_LAST_EN to repeat the last delivered sample on underrun instead of 0.
module sample_io_buffer #(
  parameter int DATA_W    = 16,
  parameter int IN_DEPTH  = 8,
  parameter int OUT_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  sample_io_buffer_if.slave          io,
  input  logic                       new_in,
  input  logic                       new_out,
  input  logic [DATA_W-1:0]          regf_rdata,
  output logic [DATA_W-1:0]          regf_wdata,
  output logic                       regf_we,
  output logic [$clog2(IN_DEPTH):0]  in_level,
  output logic [$clog2(OUT_DEPTH):0] out_level,
  output logic                       underrun,
  output logic                       overflow,
  input  logic                       clr_flags
);
  localparam int IA = $clog2(IN_DEPTH);
  localparam int OA = $clog2(OUT_DEPTH);
  localparam logic [IA:0] IN_FULL  = IN_DEPTH[IA:0];
  localparam logic [OA:0] OUT_FULL = OUT_DEPTH[OA:0];

  logic [DATA_W-1:0] in_mem  [IN_DEPTH];
  logic [DATA_W-1:0] out_mem [OUT_DEPTH];
  logic [IA-1:0] in_wp, in_rp;
  logic [OA-1:0] out_wp, out_rp;
  logic new_in_q, new_out_q, in_evt, out_evt, in_push, in_pop, out_push, out_pop;
  logic [DATA_W-1:0] fill;

  always_comb begin
    in_evt         = en & new_in & ~new_in_q;
    out_evt        = en & new_out & ~new_out_q;
    io.s_in_ready  = in_level != IN_FULL;
    io.m_out_valid = out_level != '0;
    io.m_out_data  = io.m_out_valid ? out_mem[out_rp] : '0;
    in_push        = io.s_in_valid & io.s_in_ready;
    in_pop         = in_evt & (in_level != '0);
    out_pop        = io.m_out_valid & io.m_out_ready;
    // a full FIFO still accepts when its head leaves in the same cycle
    out_push       = out_evt & ((out_level != OUT_FULL) | out_pop);
  end

`ifdef SIO_HOLD_LAST_EN
  logic [DATA_W-1:0] last_sample;
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_sample <= '0;
    else if (in_pop) last_sample <= in_mem[in_rp];
  assign fill = last_sample;
`else
  assign fill = '0;
`endif

  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wp] <= io.s_in_data;
    if (out_push) out_mem[out_wp] <= regf_rdata;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      new_in_q   <= 1'b0;
      new_out_q  <= 1'b0;
      in_wp      <= '0;
      in_rp      <= '0;
      out_wp     <= '0;
      out_rp     <= '0;
      in_level   <= '0;
      out_level  <= '0;
      regf_we    <= 1'b0;
      regf_wdata <= '0;
      underrun   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (en) begin
        new_in_q  <= new_in;
        new_out_q <= new_out;
      end
      if (in_push) in_wp <= in_wp + 1'b1;
      if (in_pop) in_rp <= in_rp + 1'b1;
      if (in_push != in_pop) in_level <= in_push ? in_level + 1'b1 : in_level - 1'b1;
      if (out_push) out_wp <= out_wp + 1'b1;
      if (out_pop) out_rp <= out_rp + 1'b1;
      if (out_push != out_pop) out_level <= out_push ? out_level + 1'b1 : out_level - 1'b1;
      regf_we <= in_evt;
      if (in_evt) regf_wdata <= in_pop ? in_mem[in_rp] : fill;
      underrun <= clr_flags ? 1'b0 : underrun | (in_evt & ~in_pop);
      overflow <= clr_flags ? 1'b0 : overflow | (out_evt & ~out_push);
    end
endmodule

// File: tb/tb_sample_io_buffer.sv
// tb_sample_io_buffer: directed vector table plus hand sequences for sample_io_buffer.
module tb_sample_io_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic new_in = 1'b0, new_out = 1'b0, clr_flags = 1'b0;
  logic [15:0] regf_rdata = '0;
  logic [15:0] regf_wdata;
  logic regf_we, underrun, overflow;
  logic [3:0] in_level, out_level;
  int checks = 0, failures = 0;

  sample_io_buffer_if #(.DATA_W(16)) io ();

  sample_io_buffer #(.DATA_W(16), .IN_DEPTH(8), .OUT_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .io(io),
    .new_in(new_in), .new_out(new_out), .regf_rdata(regf_rdata),
    .regf_wdata(regf_wdata), .regf_we(regf_we),
    .in_level(in_level), .out_level(out_level),
    .underrun(underrun), .overflow(overflow), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

`ifdef SIO_HOLD_LAST_EN
  localparam logic [15:0] FILL44 = 16'h0044;
  localparam logic [15:0] FILL_A = 16'h1234;
`else
  localparam logic [15:0] FILL44 = 16'h0000;
  localparam logic [15:0] FILL_A = 16'h0000;
`endif

  typedef struct {
    logic en, sv; logic [15:0] sd; logic ni, no; logic [15:0] rd; logic mr, cf;
    logic rdy; logic [3:0] il; logic we; logic [15:0] wd;
    logic mv; logic [15:0] md; logic [3:0] ol; logic ur, ov;
  } vec_t;
  vec_t tv [18];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic evt_in();
    new_in = 1'b1;
    step();
    new_in = 1'b0;
    step();
  endtask

  task automatic evt_out(input logic [15:0] d);
    regf_rdata = d;
    new_out = 1'b1;
    step();
    new_out = 1'b0;
    step();
  endtask

  task automatic chk_reset_outputs(input string n);
    chk({n, "_ready"}, io.s_in_ready, 1);
    chk({n, "_mvalid"}, io.m_out_valid, 0);
    chk({n, "_mdata"}, io.m_out_data, 0);
    chk({n, "_wdata"}, regf_wdata, 0);
    chk({n, "_we"}, regf_we, 0);
    chk({n, "_in_level"}, in_level, 0);
    chk({n, "_out_level"}, out_level, 0);
    chk({n, "_underrun"}, underrun, 0);
    chk({n, "_overflow"}, overflow, 0);
  endtask

  initial begin
    int cnt;
    //         en sv sd       ni no rd       mr cf  rdy il we wd       mv md       ol ur ov
    tv[0]  = '{1, 1, 16'h0011, 0, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0};
    tv[1]  = '{1, 1, 16'h0022, 0, 0, 16'h0000, 0, 0, 1, 2, 0, 16'h0000, 0, 16'h0000, 0, 0, 0};
    tv[2]  = '{1, 1, 16'h0033, 0, 0, 16'h0000, 0, 0, 1, 3, 0, 16'h0000, 0, 16'h0000, 0, 0, 0};
    tv[3]  = '{1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 1, 2, 1, 16'h0011, 0, 16'h0000, 0, 0, 0};
    tv[4]  = '{1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 2, 0, 16'h0011, 0, 16'h0000, 0, 0, 0};
    tv[5]  = '{1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 1, 1, 1, 16'h0022, 0, 16'h0000, 0, 0, 0};
    tv[6]  = '{1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0022, 0, 16'h0000, 0, 0, 0};
    tv[7]  = '{1, 1, 16'h0044, 1, 0, 16'h0000, 0, 0, 1, 1, 1, 16'h0033, 0, 16'h0000, 0, 0, 0};
    tv[8]  = '{1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0033, 0, 16'h0000, 0, 0, 0};
    tv[9]  = '{1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 1, 0, 1, 16'h0044, 0, 16'h0000, 0, 0, 0};
    tv[10] = '{1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0044, 0, 16'h0000, 0, 0, 0};
    tv[11] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0044, 0, 16'h0000, 0, 0, 0};
    tv[12] = '{1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0044, 0, 16'h0000, 0, 0, 0};
    tv[13] = '{1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0044, 0, 16'h0000, 0, 0, 0};
    tv[14] = '{1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 1, 0, 1, FILL44,   0, 16'h0000, 0, 1, 0};
    tv[15] = '{1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 1, 0, 0, FILL44,   0, 16'h0000, 0, 0, 0};
    tv[16] = '{1, 0, 16'h0000, 0, 1, 16'h00a5, 0, 0, 1, 0, 0, FILL44,   1, 16'h00a5, 1, 0, 0};
    tv[17] = '{1, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 1, 0, 0, FILL44,   0, 16'h0000, 0, 0, 0};

    io.s_in_valid = 1'b0;
    io.s_in_data = '0;
    io.m_out_ready = 1'b0;
    #12;
    chk_reset_outputs("reset");
    rst = 1'b1;
    en = 1'b1;
    step();

    for (int i = 0; i < 18; i++) begin
      en = tv[i].en; io.s_in_valid = tv[i].sv; io.s_in_data = tv[i].sd;
      new_in = tv[i].ni; new_out = tv[i].no; regf_rdata = tv[i].rd;
      io.m_out_ready = tv[i].mr; clr_flags = tv[i].cf;
      step();
      chk($sformatf("v%0d_ready", i), io.s_in_ready, tv[i].rdy);
      chk($sformatf("v%0d_in_level", i), in_level, tv[i].il);
      chk($sformatf("v%0d_we", i), regf_we, tv[i].we);
      chk($sformatf("v%0d_wdata", i), regf_wdata, tv[i].wd);
      chk($sformatf("v%0d_mvalid", i), io.m_out_valid, tv[i].mv);
      chk($sformatf("v%0d_mdata", i), io.m_out_data, tv[i].md);
      chk($sformatf("v%0d_out_level", i), out_level, tv[i].ol);
      chk($sformatf("v%0d_underrun", i), underrun, tv[i].ur);
      chk($sformatf("v%0d_overflow", i), overflow, tv[i].ov);
    end
    en = 1'b1; io.s_in_valid = 1'b0; new_in = 1'b0; new_out = 1'b0;
    io.m_out_ready = 1'b0; clr_flags = 1'b0;
    step();

    // held new_in gives one strobe, then an underrun on the empty FIFO
    io.s_in_valid = 1'b1; io.s_in_data = 16'h1234;
    step();
    io.s_in_valid = 1'b0;
    chk("hold_push_level", in_level, 1);
    new_in = 1'b1;
    cnt = 0;
    repeat (4) begin
      step();
      cnt += int'(regf_we);
    end
    new_in = 1'b0;
    step();
    cnt += int'(regf_we);
    chk("hold_we_count", cnt, 1);
    chk("hold_wdata", regf_wdata, 16'h1234);
    chk("hold_in_level", in_level, 0);
    new_in = 1'b1;
    step();
    chk("ur_we", regf_we, 1);
    chk("ur_flag", underrun, 1);
    chk("ur_wdata", regf_wdata, FILL_A);
    new_in = 1'b0;
    step();
    chk("ur_we_off", regf_we, 0);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("ur_clear", underrun, 0);

    // input FIFO fill to depth
    for (int i = 0; i < 8; i++) begin
      io.s_in_valid = 1'b1; io.s_in_data = 16'h0100 + 16'(i);
      step();
    end
    chk("full_ready", io.s_in_ready, 0);
    chk("full_level", in_level, 8);
    io.s_in_data = 16'h01ff;
    step();
    io.s_in_valid = 1'b0;
    chk("ninth_level", in_level, 8);
    new_in = 1'b1;
    step();
    new_in = 1'b0;
    chk("full_pop_data", regf_wdata, 16'h0100);
    chk("full_pop_level", in_level, 7);
    chk("full_pop_ready", io.s_in_ready, 1);
    step();

    // output overflow and drain
    for (int i = 1; i <= 9; i++) evt_out(16'(i));
    chk("ovf_level", out_level, 8);
    chk("ovf_flag", overflow, 1);
    io.m_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain%0d_valid", i), io.m_out_valid, 1);
      chk($sformatf("drain%0d_data", i), io.m_out_data, 16'(i));
      step();
    end
    chk("drain_empty", io.m_out_valid, 0);
    chk("drain_level", out_level, 0);
    io.m_out_ready = 1'b0;
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("ovf_clear", overflow, 0);

    // full output FIFO accepts a write while draining
    for (int i = 1; i <= 8; i++) evt_out(16'h0020 + 16'(i));
    chk("refill_level", out_level, 8);
    regf_rdata = 16'h0077; new_out = 1'b1; io.m_out_ready = 1'b1;
    step();
    new_out = 1'b0; io.m_out_ready = 1'b0;
    chk("fullrw_level", out_level, 8);
    chk("fullrw_overflow", overflow, 0);
    chk("fullrw_head", io.m_out_data, 16'h0022);
    step();
    evt_out(16'h0088);
    chk("full_drop_ovf", overflow, 1);
    chk("full_drop_level", out_level, 8);
    io.m_out_ready = 1'b1;
    repeat (4) step();
    io.m_out_ready = 1'b0;
    chk("half_out_level", out_level, 4);
    chk("half_out_head", io.m_out_data, 16'h0026);
    repeat (3) evt_in();
    chk("half_in_level", in_level, 4);
    new_in = 1'b1;
    step();
    chk("pre_rst_we", regf_we, 1);

    // asynchronous reset mid-cycle
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    new_in = 1'b0;
    step();
    #2;
    rst = 1'b1;
    step();
    new_in = 1'b1;
    step();
    new_in = 1'b0;
    chk("post_rst_we", regf_we, 1);
    chk("post_rst_underrun", underrun, 1);
    chk("post_rst_wdata", regf_wdata, 0);
    chk("post_rst_out_valid", io.m_out_valid, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
